ex_muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit beside the EX-stage ALU; owns the HI/LO architectural registers.

---
 rtl/ex_muldiv_unit_pkg.sv | 32 +++
 rtl/ex_muldiv_unit_iter_step.sv | 35 +++
 rtl/ex_muldiv_unit.sv | 121 ++++++++++++
 tb/tb_ex_muldiv_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: op codes and FSM states.
package ex_muldiv_unit_pkg;

    typedef enum logic [2:0] {
        MDU_NOP = 3'd0,
        MULT    = 3'd1,
        MULTU   = 3'd2,
        DIV     = 3'd3,
        DIVU    = 3'd4,
        MTHI    = 3'd5,
        MTLO    = 3'd6
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    function automatic logic is_iter_op(input logic [2:0] op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MULT) || (op == DIV);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_iter_step.sv
// One bit of iterative multiply (LSB-first shift-add) or restoring divide (MSB-first shift-subtract).
module ex_muldiv_unit_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic             div_mode_i,
    input  logic [WIDTH-1:0] acc_i,   // mul: upper product half; div: partial remainder
    input  logic [WIDTH-1:0] aux_i,   // mul: multiplier / lower product; div: dividend / quotient
    input  logic [WIDTH-1:0] opnd_i,  // mul: multiplicand; div: divisor
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] aux_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;
    logic           ge;

    always_comb begin
        sum    = {1'b0, acc_i} + (aux_i[0] ? {1'b0, opnd_i} : '0);
        rem_sh = {acc_i, aux_i[WIDTH-1]};
        diff   = rem_sh - {1'b0, opnd_i};
        ge     = (rem_sh >= {1'b0, opnd_i});
        acc_o  = '0;
        aux_o  = '0;
        if (div_mode_i) begin
            // Either result is below the divisor, so the top bit is always zero.
            acc_o = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            aux_o = {aux_i[WIDTH-2:0], ge};
        end else begin
            acc_o = sum[WIDTH:1];
            aux_o = {sum[0], aux_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; stalls EX while iterating, single-cycle MTHI/MTLO.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             ex_advance,
    input  logic             flush,
    output logic             stallreq,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output mdu_state_e       dbg_state
);

    mdu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_q, aux_q, opnd_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             div_q, neg_main_q, neg_rem_q;

    logic             start;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] acc_nx, aux_nx;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] hi_d, lo_d;

    assign start = op_valid && (state_q == ST_IDLE) && is_iter_op(op);
    assign a_neg = is_signed_op(op) && src_a[WIDTH-1];
    assign b_neg = is_signed_op(op) && src_b[WIDTH-1];
    assign a_mag = a_neg ? -src_a : src_a;
    assign b_mag = b_neg ? -src_b : src_b;

    ex_muldiv_unit_iter_step #(.WIDTH(WIDTH)) u_step (
        .div_mode_i (div_q),
        .acc_i      (acc_q),
        .aux_i      (aux_q),
        .opnd_i     (opnd_q),
        .acc_o      (acc_nx),
        .aux_o      (aux_nx)
    );

    // Sign fix-up on magnitudes; MIN/-1 and divide-by-zero fall out of this unchanged.
    always_comb begin
        prod     = {acc_nx, aux_nx};
        prod_fix = neg_main_q ? -prod : prod;
        if (div_q) begin
            lo_d = neg_main_q ? -aux_nx : aux_nx;
            hi_d = neg_rem_q ? -acc_nx : acc_nx;
        end else begin
            lo_d = prod_fix[WIDTH-1:0];
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            aux_q      <= '0;
            opnd_q     <= '0;
            div_q      <= 1'b0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else if (flush) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_BUSY;
                        cnt_q      <= '0;
                        acc_q      <= '0;
                        aux_q      <= is_div_op(op) ? a_mag : b_mag;
                        opnd_q     <= is_div_op(op) ? b_mag : a_mag;
                        div_q      <= is_div_op(op);
                        neg_main_q <= a_neg ^ b_neg;
                        neg_rem_q  <= a_neg;
                    end else if (op_valid && op == MTHI) begin
                        hi_q <= src_a;
                    end else if (op_valid && op == MTLO) begin
                        lo_q <= src_a;
                    end
                end
                ST_BUSY: begin
                    acc_q <= acc_nx;
                    aux_q <= aux_nx;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= ST_DONE;
                        hi_q    <= hi_d;
                        lo_q    <= lo_d;
                    end
                end
                ST_DONE: begin
                    // Hold until EX takes a new instruction so the finished op is not reissued.
                    if (ex_advance) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign stallreq  = !flush && (start || (state_q == ST_BUSY));
    assign busy      = (state_q != ST_IDLE);
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases plus random ops against a arithmetic model.
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  localparam int W = 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         op_valid, ex_advance, flush;
  logic [2:0]   op;
  logic [W-1:0] src_a, src_b;
  logic         stallreq, busy;
  logic [W-1:0] hi, lo;
  mdu_state_e   dbg_state;

  int total = 0;
  int bad   = 0;

  ex_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .ex_advance (ex_advance),
    .flush      (flush),
    .stallreq   (stallreq),
    .busy       (busy),
    .hi         (hi),
    .lo         (lo),
    .dbg_state  (dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model: plain integer arithmetic on 64-bit values
  function automatic void model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] eh, output logic [W-1:0] el);
    longint      sa, sb, sq, sr;
    logic [63:0] v, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    eh = '0;
    el = '0;
    case (o)
      MULT:  begin v = 64'(sa * sb); eh = v[63:32]; el = v[31:0]; end
      MULTU: begin v = {32'b0, a} * {32'b0, b}; eh = v[63:32]; el = v[31:0]; end
      DIV: begin
        if (b == 0) begin
          el = a[W-1] ? 32'd1 : 32'hFFFF_FFFF;
          eh = a;
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          v = 64'(sq);
          r = 64'(sr);
          el = v[31:0];
          eh = r[31:0];
        end
      end
      DIVU: begin
        if (b == 0) begin
          el = 32'hFFFF_FFFF;
          eh = a;
        end else begin
          el = a / b;
          eh = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic idle_inputs();
    op_valid   = 1'b0;
    op         = MDU_NOP;
    src_a      = '0;
    src_b      = '0;
    ex_advance = 1'b0;
    flush      = 1'b0;
  endtask

  // Driver: issue at a negedge in IDLE, count stall cycles, hold in DONE, then release.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int done_wait, input string tag);
    int n;
    logic [W-1:0] eh, el;
    op_valid   = 1'b1;
    op         = o;
    src_a      = a;
    src_b      = b;
    ex_advance = 1'b0;
    #1;
    n = 0;
    while (stallreq && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({tag, " stall_cycles"}, 64'(n), 64'(W + 1));
    model(o, a, b, eh, el);
    check({tag, " hi"}, 64'(hi), 64'(eh));
    check({tag, " lo"}, 64'(lo), 64'(el));
    for (int i = 0; i < done_wait; i++) begin
      check({tag, " done_stall"}, 64'(stallreq), 64'd0);
      check({tag, " done_busy"}, 64'(busy), 64'd1);
      @(negedge clk);
    end
    ex_advance = 1'b1;
    @(negedge clk);
    ex_advance = 1'b0;
    op_valid   = 1'b0;
    check({tag, " back_idle"}, 64'(busy), 64'd0);
  endtask

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] specials [5];
    specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
    return $urandom();
  endfunction

  logic [W-1:0] h0, l0;
  logic [2:0]   rop;

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset stallreq", 64'(stallreq), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // directed arithmetic corners
    run_op(MULT,  32'hFFFF_FFFE, 32'h0000_0003, 0, "mult_neg");
    check("mult_neg hi const", 64'(hi), 64'hFFFF_FFFF);
    check("mult_neg lo const", 64'(lo), 64'hFFFF_FFFA);
    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");
    check("multu_max hi const", 64'(hi), 64'hFFFF_FFFE);
    run_op(DIV,   32'hFFFF_FFF9, 32'h0000_0002, 0, "div_m7_2");
    check("div_m7_2 lo const", 64'(lo), 64'hFFFF_FFFD);
    run_op(DIVU,  32'd7, 32'd2, 0, "divu_7_2");
    run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, "div_min_m1");
    check("div_min_m1 lo const", 64'(lo), 64'h8000_0000);
    run_op(DIVU,  32'd5, 32'd0, 0, "divu_by0");
    run_op(DIV,   32'hFFFF_FFFB, 32'd0, 0, "div_neg_by0");

    // flush during BUSY
    h0 = hi;
    l0 = lo;
    op_valid = 1'b1; op = MULT; src_a = 32'h1234_5678; src_b = 32'h9ABC_DEF0;
    repeat (10) @(negedge clk);
    check("flush pre busy", 64'(busy), 64'd1);
    flush = 1'b1; op_valid = 1'b0;
    #1 check("flush cycle stallreq", 64'(stallreq), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    check("flush stallreq", 64'(stallreq), 64'd0);
    check("flush hi kept", 64'(hi), 64'(h0));
    check("flush lo kept", 64'(lo), 64'(l0));

    // flush beats start and MT write
    op_valid = 1'b1; op = DIV; src_a = 32'd100; src_b = 32'd3; flush = 1'b1;
    #1 check("flush_start stallreq", 64'(stallreq), 64'd0);
    @(negedge clk);
    check("flush_start busy", 64'(busy), 64'd0);
    op = MTHI; src_a = 32'hDEAD_BEEF;
    @(negedge clk);
    check("flush_mthi hi kept", 64'(hi), 64'(h0));
    idle_inputs();

    // non-mdu op and op_valid=0 have no effect
    op_valid = 1'b1; op = MDU_NOP; src_a = 32'h5555_5555;
    #1 check("nop stallreq", 64'(stallreq), 64'd0);
    @(negedge clk);
    check("nop busy", 64'(busy), 64'd0);
    op_valid = 1'b0; op = MULT;
    #1 check("novalid stallreq", 64'(stallreq), 64'd0);
    @(negedge clk);
    check("novalid busy", 64'(busy), 64'd0);
    idle_inputs();

    // DONE holds without restart while EX is stalled; then MTLO / MTHI
    run_op(DIV, 32'd1000, 32'hFFFF_FFF9, 3, "div_hold");
    op_valid = 1'b1; op = MTLO; src_a = 32'h0000_1234;
    #1 check("mtlo stallreq", 64'(stallreq), 64'd0);
    @(negedge clk);
    check("mtlo lo", 64'(lo), 64'h0000_1234);
    op = MTHI; src_a = 32'hCAFE_0001;
    @(negedge clk);
    check("mthi hi", 64'(hi), 64'hCAFE_0001);
    check("mthi lo kept", 64'(lo), 64'h0000_1234);
    idle_inputs();

    // reset mid-operation clears hi/lo
    op_valid = 1'b1; op = MULTU; src_a = 32'd9; src_b = 32'd9;
    repeat (5) @(negedge clk);
    rst = 1'b1; op_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid hi", 64'(hi), 64'd0);
    check("rst_mid lo", 64'(lo), 64'd0);
    check("rst_mid busy", 64'(busy), 64'd0);
    idle_inputs();
    @(negedge clk);

    // random operations
    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 3))
        0: rop = MULT;
        1: rop = MULTU;
        2: rop = DIV;
        default: rop = DIVU;
      endcase
      run_op(rop, rand_operand(), rand_operand(), $urandom_range(0, 2), $sformatf("rand%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
